// File: rtl/z16_board_pkg.sv
// Shared board-level constants and FSM encoding for the button input path.
package z16_board_pkg;

  localparam int CLK_HZ = 27000000;

  // 10 ms debounce window, 200 ms repeat period at CLK_HZ
  localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;
  localparam int REPEAT_DELAY_DEFAULT    = 0;
  localparam int REPEAT_PERIOD_DEFAULT   = CLK_HZ / 5;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } btn_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; reset value is a parameter
// so the flops come up at the input's inactive level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronize, debounce, press/release/repeat pulses,
// plus sticky event/overrun flags cleared by i_ack.
//
// state          | meaning
// S_IDLE         | released and stable
// S_PRESS_WAIT   | pressed level seen, counting stable cycles
// S_HELD         | accepted press; repeat counter running
// S_RELEASE_WAIT | released level seen while held, counting stable cycles
module button_conditioner
  import z16_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  input  logic i_ack,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_event,
  output logic o_overrun
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_V    = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PER_V    = CNT_W'(REPEAT_PERIOD);
  localparam bit REPEAT_EN = (REPEAT_DELAY > 0);
  localparam logic IDLE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic             pin_sync;
  logic             btn;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rcnt;
  logic [CNT_W-1:0] rcnt_inc;
  logic             rpt_phase;
  logic             press_set;
  logic             rel_set;
  logic             rpt_set;
  logic             new_event;

  sync_2ff #(.RESET_VAL(IDLE_PIN)) u_sync (
    .clk  (i_clk),
    .rst_n(i_rst),
    .d    (i_button),
    .q    (pin_sync)
  );

  assign btn = pin_sync ^ ACTIVE_LOW;

  // rpt_phase=0 waits out the initial delay, rpt_phase=1 the steady period
  always_comb begin
    rcnt_inc  = rcnt + 1'b1;
    press_set = (state == S_PRESS_WAIT) && btn && (cnt == DEB_LAST);
    rel_set   = (state == S_RELEASE_WAIT) && !btn && (cnt == DEB_LAST);
    rpt_set   = REPEAT_EN && (state == S_HELD) && btn &&
                (rpt_phase ? (rcnt_inc == PER_V) : (rcnt_inc == DLY_V));
    new_event = press_set | rpt_set;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      rpt_phase <= 1'b0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_repeat  <= 1'b0;
      o_event   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_press   <= press_set;
      o_release <= rel_set;
      o_repeat  <= rpt_set;
      // a new event always wins over a simultaneous acknowledge
      o_event   <= (o_event & ~i_ack) | new_event;
      o_overrun <= (o_overrun & ~i_ack) | (new_event & o_event & ~i_ack);
      case (state)
        S_IDLE: begin
          if (btn) begin
            state <= S_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!btn) begin
            state <= S_IDLE;
          end else if (cnt == DEB_LAST) begin
            state     <= S_HELD;
            o_level   <= 1'b1;
            rcnt      <= '0;
            rpt_phase <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HELD: begin
          if (!btn) begin
            state <= S_RELEASE_WAIT;
            cnt   <= '0;
          end else if (rpt_set) begin
            rcnt      <= '0;
            rpt_phase <= 1'b1;
          end else if (REPEAT_EN) begin
            rcnt <= rcnt_inc;
          end
        end
        S_RELEASE_WAIT: begin
          // rcnt is left untouched so a rejected release bounce resumes the repeat timing
          if (btn) begin
            state <= S_HELD;
          end else if (cnt == DEB_LAST) begin
            state   <= S_IDLE;
            o_level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: unit "a" without auto-repeat, unit "b" with delay 10 / period 5,
// both with a 4-cycle debounce and an active-low pin.
module tb_button_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_button, a_ack, b_button, b_ack;
  logic a_level, a_press, a_release, a_repeat, a_event, a_overrun;
  logic b_level, b_press, b_release, b_repeat, b_event, b_overrun;

  int total = 0;
  int bad   = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(5), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_button(a_button), .i_ack(a_ack),
    .o_level(a_level), .o_press(a_press), .o_release(a_release),
    .o_repeat(a_repeat), .o_event(a_event), .o_overrun(a_overrun)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_button(b_button), .i_ack(b_ack),
    .o_level(b_level), .o_press(b_press), .o_release(b_release),
    .o_repeat(b_repeat), .o_event(b_event), .o_overrun(b_overrun)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a_button = 1'b1; a_ack = 1'b0; b_button = 1'b1; b_ack = 1'b0;
    repeat (3) tick();
    check("rst_a_level", a_level, 1'b0);
    check("rst_a_press", a_press, 1'b0);
    check("rst_a_release", a_release, 1'b0);
    check("rst_a_repeat", a_repeat, 1'b0);
    check("rst_a_event", a_event, 1'b0);
    check("rst_a_overrun", a_overrun, 1'b0);
    check("rst_b_level", b_level, 1'b0);
    check("rst_b_event", b_event, 1'b0);
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_a_level", a_level, 1'b0);
    check("idle_a_press", a_press, 1'b0);

    // clean press: pin low before edge 0, press pulse after edge 6
    a_button = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("press_pulse_e%0d", k), a_press, k == 6);
      check($sformatf("press_level_e%0d", k), a_level, k >= 6);
      check($sformatf("press_event_e%0d", k), a_event, k >= 6);
    end
    repeat (3) tick();
    check("press_event_held", a_event, 1'b1);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    check("ack_event_clr", a_event, 1'b0);
    check("ack_overrun", a_overrun, 1'b0);

    // clean release
    a_button = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rel_pulse_e%0d", k), a_release, k == 6);
      check($sformatf("rel_level_e%0d", k), a_level, k < 6);
      check($sformatf("rel_event_e%0d", k), a_event, 1'b0);
    end
    repeat (3) tick();

    // press bounce: 0,0,1,0,0 then released
    for (int k = 0; k < 12; k++) begin
      a_button = (k < 2) ? 1'b0 : (k == 2) ? 1'b1 : (k < 5) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("bnc_press_e%0d", k), a_press, 1'b0);
      check($sformatf("bnc_level_e%0d", k), a_level, 1'b0);
      check($sformatf("bnc_event_e%0d", k), a_event, 1'b0);
    end

    a_button = 1'b0;
    repeat (8) tick();
    check("held_level", a_level, 1'b1);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    check("held_ack_event", a_event, 1'b0);

    // release bounce of two cycles while held
    for (int k = 0; k < 12; k++) begin
      a_button = (k < 2) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("bnc_rel_e%0d", k), a_release, 1'b0);
      check($sformatf("bnc_rel_level_e%0d", k), a_level, 1'b1);
      check($sformatf("bnc_rel_press_e%0d", k), a_press, 1'b0);
    end
    a_button = 1'b1;
    repeat (8) tick();
    check("bnc_final_level", a_level, 1'b0);
    check("bnc_final_event", a_event, 1'b0);

    // auto-repeat on unit b: press at 6, repeats at 16,21,...,41, release at 50
    b_button = 1'b0;
    for (int k = 0; k < 56; k++) begin
      tick();
      check($sformatf("rpt_press_e%0d", k), b_press, k == 6);
      check($sformatf("rpt_repeat_e%0d", k), b_repeat,
            (k == 16) || (k == 21) || (k == 26) || (k == 31) || (k == 36) || (k == 41));
      check($sformatf("rpt_release_e%0d", k), b_release, k == 50);
      check($sformatf("rpt_level_e%0d", k), b_level, (k >= 6) && (k < 50));
      check($sformatf("rpt_event_e%0d", k), b_event, k >= 6);
      check($sformatf("rpt_overrun_e%0d", k), b_overrun,
            ((k >= 16) && (k < 21)) || (k >= 26));
      if (k == 20) b_ack = 1'b1;
      if (k == 21) b_ack = 1'b0;
      if (k == 43) b_button = 1'b1;
    end
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    check("rpt_ack_event", b_event, 1'b0);
    check("rpt_ack_overrun", b_overrun, 1'b0);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    check("idle_ack_event", b_event, 1'b0);
    check("idle_ack_overrun", b_overrun, 1'b0);

    // reset during press debounce, then re-debounce with pin held
    a_button = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #2;
    check("midrst_pw_press", a_press, 1'b0);
    check("midrst_pw_level", a_level, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("postrst1_press_e%0d", k), a_press, k == 6);
      check($sformatf("postrst1_release_e%0d", k), a_release, 1'b0);
      check($sformatf("postrst1_level_e%0d", k), a_level, k >= 6);
    end

    // reset while held: outputs drop without waiting for a clock edge
    rst_n = 1'b0;
    #2;
    check("midrst_held_level", a_level, 1'b0);
    check("midrst_held_event", a_event, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("postrst2_press_e%0d", k), a_press, k == 6);
      check($sformatf("postrst2_release_e%0d", k), a_release, 1'b0);
      check($sformatf("postrst2_event_e%0d", k), a_event, k >= 6);
    end
    a_button = 1'b1;
    repeat (8) tick();
    check("end_level", a_level, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side board conditioner that feeds the CPU's button input; it complements the output-side LED path.
- Takes a raw, bouncing, asynchronous push-button pin and turns it into clean, single-clock events.
- Steps: synchronize, debounce, detect press/release edges, optional auto-repeat while held.
- Events are latched in a sticky flag with acknowledge, so a CPU on a divided clock enable cannot miss a press.

Parameters:
- DEBOUNCE_CYCLES, 270000, stable-input cycles required to accept a level change (10 ms at 27 MHz); must be >= 1.
- REPEAT_DELAY, 0, cycles held in HELD before the first o_repeat; 0 disables auto-repeat.
- REPEAT_PERIOD, 5400000, cycles between successive o_repeat pulses after the first; must be >= 1.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (board button); 0 = pin reads 1 when pressed.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-low.
- i_button  in  1  raw button pin, asynchronous to i_clk.
- i_ack  in  1  clears o_event and o_overrun; synchronous.
- o_level  out  1  debounced pressed level, 1 = pressed.
- o_press  out  1  one-cycle pulse on accepted press.
- o_release  out  1  one-cycle pulse on accepted release.
- o_repeat  out  1  one-cycle pulse per auto-repeat tick.
- o_event  out  1  sticky: set by o_press or o_repeat, held until i_ack.
- o_overrun  out  1  sticky: an event arrived while o_event was already pending.

Behaviour:
- Reset (i_rst=0, async): sync flops take the not-pressed pin level (ACTIVE_LOW ? 1 : 0); FSM goes to S_IDLE; counters 0; all outputs 0.
- Synchronizer: 2 flops. btn = sync2 XOR ACTIVE_LOW, so btn=1 means pressed. FSM sees only btn.
- All outputs are registered.
- Debounce counter cnt: width clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).
- S_IDLE:
  - btn=1 -> S_PRESS_WAIT, cnt=0.
- S_PRESS_WAIT:
  - btn=0 -> S_IDLE (bounce rejected, no pulse).
  - Otherwise cnt++.
  - When cnt==DEBOUNCE_CYCLES-1 and btn=1 -> S_HELD, o_press=1 for one cycle, o_level=1, repeat counter rcnt=0.
- S_HELD:
  - btn=0 -> S_RELEASE_WAIT, cnt=0; rcnt freezes.
  - Otherwise, if REPEAT_DELAY>0, rcnt++.
  - First o_repeat fires when rcnt reaches REPEAT_DELAY; later ones fire every REPEAT_PERIOD cycles.
- S_RELEASE_WAIT:
  - btn=1 -> S_HELD (bounce rejected); rcnt resumes from its frozen value, no o_press.
  - Otherwise cnt++.
  - At cnt==DEBOUNCE_CYCLES-1 -> S_IDLE, o_release=1 for one cycle, o_level=0.
- Latency: a clean press settling before rising edge 0 gives o_press high after edge DEBOUNCE_CYCLES+2. Release timing is symmetric.
- o_press, o_release and o_repeat are mutually exclusive in any cycle.
- o_event:
  - Next value = (o_event AND NOT i_ack) OR new_event, where new_event = o_press or o_repeat being set this edge.
  - Set wins over a simultaneous i_ack.
- o_overrun:
  - Set when new_event occurs while o_event=1 and i_ack=0.
  - Cleared by i_ack unless it is set in the same cycle (set wins).
- i_ack while o_event=0 has no effect.
- Mid-operation reset: immediate return to the reset state; no pulses are emitted on reset deassertion, even if the button is held. A held button is then re-debounced from S_IDLE and yields a fresh o_press.
- The synchronizer input has no reset dependency on the pin; the first DEBOUNCE_CYCLES+2 cycles after reset never emit pulses.

Decomposition:
- Shared package z16_board_pkg holds:
  - FSM state encoding: S_IDLE=2'd0, S_PRESS_WAIT=2'd1, S_HELD=2'd2, S_RELEASE_WAIT=2'd3.
  - CLK_HZ=27000000.
  - Default debounce and repeat constants derived from CLK_HZ.
- Natural sub-module: sync_2ff, a 2-flop synchronizer with a reset-value parameter, reused for any later board inputs.
- FSM, counters and sticky flags stay in button_conditioner.

Test Plan:
- Setup for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=0, ACTIVE_LOW=1.
- Clean press: pin 1->0 before edge 0 and held -> o_press=1 after edge 6 only, o_level=1 from edge 6, o_event=1 until i_ack pulse, then 0.
- Bounce: pin 0 for 2 cycles, 1 for 1, 0 for 2, then 1 -> no o_press, o_level stays 0, o_event 0; then a release bounce in S_HELD that lasts under 4 cycles -> no o_release.
- Release: from S_HELD, pin to 1 and held -> o_release after edge 6 relative to the change, o_level=0, o_event unchanged.
- Auto-repeat: REPEAT_DELAY=10, REPEAT_PERIOD=5, hold 40 cycles -> o_repeat at HELD-relative cycles 10, 15, 20, 25, 30, 35; second event without ack -> o_overrun=1; i_ack on the same cycle as a repeat -> o_event stays 1.
- Reset mid-press: assert i_rst=0 during S_PRESS_WAIT and again in S_HELD -> outputs 0 immediately (async); after release of reset with pin held low -> o_press after exactly 6 edges, no o_release.
